// File: rtl/matmul_index_seq.sv
// i/j/k loop sequencer for C = A x B over N x N matrices; emits element addresses and accumulator controls.
// Optional `MATMUL_CYCLE_CNT_EN` adds a 32-bit busy-cycle counter output (cycle_cnt).
module matmul_index_seq #(
  parameter int word_size = 16,
  parameter int idx_size  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [word_size-1:0] dim_n,
  input  logic                 stall,
  output logic                 valid,
  output logic                 busy,
  output logic                 done,
  output logic [idx_size-1:0]  idx_i,
  output logic [idx_size-1:0]  idx_j,
  output logic [idx_size-1:0]  idx_k,
  output logic [word_size-1:0] addr_a,
  output logic [word_size-1:0] addr_b,
  output logic [word_size-1:0] addr_c,
  output logic                 acc_clr,
  output logic                 acc_wr
`ifdef MATMUL_CYCLE_CNT_EN
  ,
  output logic [31:0]          cycle_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  logic [word_size-1:0] n_lat;
  logic [word_size-1:0] base_i;
  logic [idx_size-1:0]  nm1;
  logic                 k_last, j_last, i_last;

  assign k_last = (idx_k == nm1);
  assign j_last = (idx_j == nm1);
  assign i_last = (idx_i == nm1);

  // base_i tracks i*N; addr_b advances by N per k step so no k*N multiply is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      n_lat   <= '0;
      nm1     <= '0;
      base_i  <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      idx_i   <= '0;
      idx_j   <= '0;
      idx_k   <= '0;
      addr_a  <= '0;
      addr_b  <= '0;
      addr_c  <= '0;
      acc_clr <= 1'b0;
      acc_wr  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            n_lat  <= dim_n;
            nm1    <= idx_size'(dim_n - word_size'(1));
            base_i <= '0;
            idx_i  <= '0;
            idx_j  <= '0;
            idx_k  <= '0;
            addr_a <= '0;
            addr_b <= '0;
            addr_c <= '0;
            busy   <= 1'b1;
            if (dim_n != '0) begin
              state   <= RUN;
              valid   <= 1'b1;
              acc_clr <= 1'b1;
              acc_wr  <= (idx_size'(dim_n - word_size'(1)) == '0);
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (!stall) begin
            if (k_last && j_last && i_last) begin
              state   <= DONE;
              valid   <= 1'b0;
              done    <= 1'b1;
              acc_clr <= 1'b0;
              acc_wr  <= 1'b0;
              idx_i   <= '0;
              idx_j   <= '0;
              idx_k   <= '0;
              addr_a  <= '0;
              addr_b  <= '0;
              addr_c  <= '0;
              base_i  <= '0;
            end else if (!k_last) begin
              idx_k   <= idx_k + idx_size'(1);
              addr_a  <= addr_a + word_size'(1);
              addr_b  <= addr_b + n_lat;
              acc_clr <= 1'b0;
              acc_wr  <= ((idx_k + idx_size'(1)) == nm1);
            end else if (!j_last) begin
              // k wraps with N>1 here, so the new step is a clear, never a write.
              idx_k   <= '0;
              idx_j   <= idx_j + idx_size'(1);
              addr_a  <= base_i;
              addr_b  <= word_size'(idx_j) + word_size'(1);
              addr_c  <= addr_c + word_size'(1);
              acc_clr <= 1'b1;
              acc_wr  <= 1'b0;
            end else begin
              idx_k   <= '0;
              idx_j   <= '0;
              idx_i   <= idx_i + idx_size'(1);
              base_i  <= base_i + n_lat;
              addr_a  <= base_i + n_lat;
              addr_b  <= '0;
              addr_c  <= base_i + n_lat;
              acc_clr <= 1'b1;
              acc_wr  <= 1'b0;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MATMUL_CYCLE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
    end else if (state == IDLE && start) begin
      cycle_cnt <= '0;
    end else if (busy) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end
`endif

endmodule
